muldiv_unit: RTL



---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_if.sv | 30 +++
 rtl/muldiv_negate.sv | 16 +
 rtl/muldiv_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op codes, FSM states and sizing helper for muldiv_unit
//
// Purpose: holds the common definitions for the multiply/divide engine.
//   - MD_* : encoding of the op input (MULT, MULTU, DIV, DIVU)
//   - md_state_t : engine FSM states
//   - cnt_width() : bit width of the iteration counter for a given operand width
package muldiv_pkg;

    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_DIV   = 2'd2;
    localparam logic [1:0] MD_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_t;

    // The counter only has to reach width-1, so clog2(width) bits suffice.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - start/busy/done request interface of muldiv_unit
//
// Purpose: groups the control-unit handshake and the Hi/Lo result path.
// Signals:
//   start, op[1:0], a, b        : request from the control unit
//   busy, done, hi, lo, div_zero: status and results from the engine
// Modports: master (control unit side), slave (engine side).
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, div_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, div_zero
    );
endinterface

// File: rtl/muldiv_negate.sv
// rtl/muldiv_negate.sv - conditional two's-complement negate
//
// Purpose: q_o = en_i ? -d_i : d_i, used for operand magnitudes and result fix-up.
// Ports:
//   en_i      : negate when high
//   d_i[W-1:0]: input value
//   q_o[W-1:0]: (conditionally) negated value
module muldiv_negate #(
    parameter int W = 32
) (
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    assign q_o = en_i ? ('0 - d_i) : d_i;
endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative signed/unsigned multiply/divide engine
//
// Purpose: radix-2 shift-add multiply and restoring divide sharing one
// 2*WIDTH accumulator, one bit per cycle, with a sign fix-up cycle at the end.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : muldiv_if.slave (start/op/a/b in; busy/done/hi/lo/div_zero out)
// Configuration macro: MULDIV_DIV0_DETECT_EN
//   defined   - divide by zero skips the iterations, flags div_zero, keeps hi/lo
//   undefined - divide by zero runs the raw algorithm, div_zero is always 0
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int CNT_W = cnt_width(WIDTH);

    md_state_t          state_q;
    logic               busy_q;
    logic               done_q;
    logic               is_div_q;
    logic               neg_lo_q;   // negate product (MULT) or quotient (DIV)
    logic               neg_hi_q;   // negate remainder (DIV, dividend negative)
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   d_q;        // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    // Request decode and operand magnitudes
    logic             op_div;
    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign op_div    = (bus.op == MD_DIV) || (bus.op == MD_DIVU);
    assign op_signed = (bus.op == MD_MULT) || (bus.op == MD_DIV);
    assign a_neg     = op_signed & bus.a[WIDTH-1];
    assign b_neg     = op_signed & bus.b[WIDTH-1];

    muldiv_negate #(.W(WIDTH)) u_neg_a (.en_i(a_neg), .d_i(bus.a), .q_o(a_mag));
    muldiv_negate #(.W(WIDTH)) u_neg_b (.en_i(b_neg), .d_i(bus.b), .q_o(b_mag));

    // One iteration. Multiply: acc = {partial, multiplier}, shifted right.
    // Divide: acc = {remainder, dividend/quotient}, shifted left.
    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] rem_ext;
    logic [WIDTH:0] sub_diff;

    always_comb begin
        add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, d_q};
        rem_ext  = acc_q[2*WIDTH-1:WIDTH-1];
        sub_diff = rem_ext - {1'b0, d_q};
        acc_d    = acc_q;
        if (is_div_q) begin
            // rem_ext < 2*divisor, so a failed subtract leaves rem_ext[WIDTH]=0
            if (!sub_diff[WIDTH])
                acc_d = {sub_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else
                acc_d = {rem_ext[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else if (acc_q[0]) begin
            acc_d = {add_sum, acc_q[WIDTH-1:1]};
        end else begin
            acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
        end
    end

    // Sign fix-up of the finished result
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    muldiv_negate #(.W(2*WIDTH)) u_neg_prod (
        .en_i(neg_lo_q & ~is_div_q), .d_i(acc_q), .q_o(prod_fix)
    );
    muldiv_negate #(.W(WIDTH)) u_neg_quo (
        .en_i(neg_lo_q), .d_i(acc_q[WIDTH-1:0]), .q_o(quo_fix)
    );
    muldiv_negate #(.W(WIDTH)) u_neg_rem (
        .en_i(neg_hi_q), .d_i(acc_q[2*WIDTH-1:WIDTH]), .q_o(rem_fix)
    );

`ifdef MULDIV_DIV0_DETECT_EN
    logic div0_q;
    logic div_zero_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            is_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= '0;
            d_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
`ifdef MULDIV_DIV0_DETECT_EN
            div0_q     <= 1'b0;
            div_zero_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        is_div_q <= op_div;
                        neg_lo_q <= a_neg ^ b_neg;
                        neg_hi_q <= a_neg;
                        d_q      <= op_div ? b_mag : a_mag;
                        acc_q    <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
`ifdef MULDIV_DIV0_DETECT_EN
                        div0_q   <= op_div && (bus.b == '0);
                        if (op_div && (bus.b == '0))
                            state_q <= FIX;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1))
                        state_q <= FIX;
                end
                FIX: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
`ifdef MULDIV_DIV0_DETECT_EN
                    div_zero_q <= div0_q;
                    if (!div0_q) begin
`else
                    begin
`endif
                        if (is_div_q) begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end else begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
`ifdef MULDIV_DIV0_DETECT_EN
    assign bus.div_zero = div_zero_q;
`else
    assign bus.div_zero = 1'b0;
`endif

endmodule
